// File: rtl/vga_grid_renderer.sv
// rtl/vga_grid_renderer.sv - 3-stage VGA pixel path drawing a 40x30 cell board
module vga_grid_renderer #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int CELL_SHIFT = 4,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  output logic [10:0] rd_addr,
  input  logic [1:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_tick
);

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [5:0] COL_LAST   = 6'(GRID_W - 1);
  localparam logic [4:0] ROW_LAST   = 5'(GRID_H - 1);

  // stage 1 decode results
  logic       in_range;
  logic       visible;
  logic       hs_n;
  logic       vs_n;
  logic       wall;
  logic       tick_hit;
  logic [5:0] col;
  logic [4:0] row;

  // stage 1 registers
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [9:0]  prev_h_q, prev_h_d;
  logic [9:0]  prev_v_q, prev_v_d;
  logic        vis1_q, vis1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        wall1_q, wall1_d;
  logic        tick1_q, tick1_d;

  // stage 2 registers (aligned with the RAM's registered read)
  logic        vis2_q, vis2_d;
  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        wall2_q, wall2_d;
  logic        tick2_q, tick2_d;

  // stage 3 output registers
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [3:0]  red_q, red_d;
  logic [3:0]  green_q, green_d;
  logic [3:0]  blue_q, blue_d;
  logic        tick_q, tick_d;

  // Decode the raw counter pair into visibility, sync, cell position and tick request
  always_comb begin
    col      = 6'(h_count >> CELL_SHIFT);
    row      = 5'(v_count >> CELL_SHIFT);
    in_range = (h_count <= H_LAST) && (v_count <= V_LAST);
    visible  = (h_count < H_VIS) && (v_count < V_VIS);
    hs_n     = !(in_range && (h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    vs_n     = !(in_range && (v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
    wall     = visible && ((col == 6'd0) || (col == COL_LAST) ||
                           (row == 5'd0) || (row == ROW_LAST));
    // counters may dwell on a value; only the first sample of (0, V_VISIBLE) fires
    tick_hit = (h_count == 10'd0) && (v_count == V_VIS) &&
               ((h_count != prev_h_q) || (v_count != prev_v_q));
  end

  // Next-state for all three pipeline stages
  always_comb begin
    rd_addr_d = {row, col};
    prev_h_d  = h_count;
    prev_v_d  = v_count;
    vis1_d    = visible;
    hs1_d     = hs_n;
    vs1_d     = vs_n;
    wall1_d   = wall;
    tick1_d   = tick_hit;

    vis2_d    = vis1_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
    wall2_d   = wall1_q;
    tick2_d   = tick1_q;

    hsync_d   = hs2_q;
    vsync_d   = vs2_q;
    tick_d    = tick2_q;
    red_d     = 4'h0;
    green_d   = 4'h0;
    blue_d    = 4'h0;
    if (vis2_q) begin
      if (wall2_q) begin
        red_d   = 4'h8;
        green_d = 4'h8;
        blue_d  = 4'h8;
      end else begin
        case (rd_data)
          2'd1:    green_d = 4'hF;
          2'd2:    blue_d  = 4'hF;
          2'd3:    red_d   = 4'hF;
          default: ;
        endcase
      end
    end
  end

  // Pipeline registers with synchronous flush on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= 11'd0;
      prev_h_q  <= 10'd0;
      prev_v_q  <= 10'd0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      wall1_q   <= 1'b0;
      tick1_q   <= 1'b0;
      vis2_q    <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      wall2_q   <= 1'b0;
      tick2_q   <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      red_q     <= 4'h0;
      green_q   <= 4'h0;
      blue_q    <= 4'h0;
      tick_q    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      prev_h_q  <= prev_h_d;
      prev_v_q  <= prev_v_d;
      vis1_q    <= vis1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      wall1_q   <= wall1_d;
      tick1_q   <= tick1_d;
      vis2_q    <= vis2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      wall2_q   <= wall2_d;
      tick2_q   <= tick2_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      tick_q    <= tick_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb/tb_vga_grid_renderer.sv - directed self-checking bench for vga_grid_renderer
module tb_vga_grid_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_count = 10'd0;
  logic [9:0]  v_count = 10'd0;
  logic [10:0] rd_addr;
  logic [1:0]  rd_data = 2'd0;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_tick;
  logic [11:0] rgb;

  logic [1:0]  mem [0:2047];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  logic [9:0] ph0 = 10'd0, ph1 = 10'd0, ph2 = 10'd0;
  logic [9:0] pv0 = 10'd0, pv1 = 10'd0, pv2 = 10'd0;

  vga_grid_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  // synchronous board RAM model
  always @(posedge clk) rd_data <= mem[rd_addr];

  // drive one counter pair, advance one edge, sample 1 time unit later;
  // afterwards outputs reflect the pair held in ph2/pv2
  task automatic cyc(input logic [9:0] h, input logic [9:0] v);
    ph2 = ph1; ph1 = ph0; ph0 = h;
    pv2 = pv1; pv1 = pv0; pv0 = v;
    h_count = h;
    v_count = v;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lows;
    int vs_lows;
    int ticks;
    int drive_cyc [$];
    int tick_cyc [$];
    int t0, t1, d0, d1;
    logic [9:0] hh;

    for (int i = 0; i < 2048; i++) mem[i] = 2'd0;
    mem[11'h0CA] = 2'd1;                       // row 3, col 10
    mem[11'h0CB] = 2'd2;                       // row 3, col 11
    mem[11'h0CC] = 2'd3;                       // row 3, col 12
    mem[11'd1895] = 2'd3;                      // row 29, col 39 (wall cell)
    for (int c = 40; c < 50; c++) mem[6*64 + c] = 2'd3;  // blanking cells on line 100
    mem[11'd786] = 2'd2;                       // row 12, col 18

    // reset held two cycles with arbitrary counts
    rst = 1'b1;
    cyc(10'd300, 10'd200);
    cyc(10'd300, 10'd200);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'h000);

    // first valid pixel appears on the third edge after release
    rst = 1'b0;
    cyc(10'd0, 10'd0);
    check("rel_e1_rgb", 32'(rgb), 32'h000);
    check("rel_e1_addr", 32'(rd_addr), 32'h000);
    cyc(10'd0, 10'd0);
    check("rel_e2_rgb", 32'(rgb), 32'h000);
    cyc(10'd0, 10'd0);
    check("wall_00_rgb", 32'(rgb), 32'h888);
    check("wall_00_hsync", 32'(hsync), 32'd1);

    // wall corner, then cell codes 1/2/3/0 along row 3
    cyc(10'd639, 10'd479);
    check("wall_00_hold", 32'(rgb), 32'h888);
    cyc(10'd160, 10'd48);
    check("addr_160_48", 32'(rd_addr), 32'h0CA);
    cyc(10'd176, 10'd48);
    check("wall_639_479", 32'(rgb), 32'h888);
    check("addr_176_48", 32'(rd_addr), 32'h0CB);
    cyc(10'd192, 10'd48);
    check("code1_green", 32'(rgb), 32'h0F0);
    cyc(10'd208, 10'd48);
    check("code2_blue", 32'(rgb), 32'h00F);
    cyc(10'd208, 10'd48);
    check("code3_red", 32'(rgb), 32'hF00);
    cyc(10'd208, 10'd48);
    check("code0_black", 32'(rgb), 32'h000);

    // hsync sweep across horizontal blanking on line 100
    lows = 0;
    for (int i = 0; i < 162; i++) begin
      cyc(10'(640 + ((i < 160) ? i : 159)), 10'd100);
      if (i >= 2) begin
        check("hsync_sweep", 32'(hsync),
              (ph2 >= 10'd656 && ph2 <= 10'd751) ? 32'd0 : 32'd1);
        check("hblank_rgb", 32'(rgb), 32'h000);
        if (!hsync) lows++;
      end
    end
    check("hsync_low_count", 32'(lows), 32'd96);

    // two passes over lines 479..493 with h dwelling two cycles at 799
    vs_lows = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 479; v <= 493; v++) begin
        for (int h = 0; h <= 800; h++) begin
          hh = (h == 800) ? 10'd799 : 10'(h);
          cyc(hh, 10'(v));
          if (hh == 10'd0 && v == 480) drive_cyc.push_back(cyc_n);
          check("vsync_frame", 32'(vsync),
                (pv2 == 10'd490 || pv2 == 10'd491) ? 32'd0 : 32'd1);
          if (!vsync) vs_lows++;
          if (frame_tick) tick_cyc.push_back(cyc_n);
        end
      end
    end
    t0 = (tick_cyc.size() > 0) ? tick_cyc[0] : -1;
    t1 = (tick_cyc.size() > 1) ? tick_cyc[1] : -1;
    d0 = (drive_cyc.size() > 0) ? drive_cyc[0] : -100;
    d1 = (drive_cyc.size() > 1) ? drive_cyc[1] : -100;
    check("vsync_low_count", 32'(vs_lows), 32'd3204);
    check("tick_count", 32'(tick_cyc.size()), 32'd2);
    check("tick0_latency", 32'(t0), 32'(d0 + 2));
    check("tick1_latency", 32'(t1), 32'(d1 + 2));
    check("tick_period", 32'(t1 - t0), 32'd12015);

    // counters holding (0,480) for several cycles still yield one tick
    ticks = 0;
    cyc(10'd5, 10'd480);
    for (int i = 0; i < 3; i++) begin
      cyc(10'd0, 10'd480);
      if (frame_tick) ticks++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(10'd1, 10'd480);
      if (frame_tick) ticks++;
    end
    check("tick_dwell_once", 32'(ticks), 32'd1);

    // out-of-range counts: no sync, no pixels, address still computed
    cyc(10'd700, 10'd600);
    check("oor_addr_a", 32'(rd_addr), 32'h16B);
    cyc(10'd1000, 10'd491);
    check("oor_addr_b", 32'(rd_addr), 32'h7BE);
    cyc(10'd1000, 10'd491);
    check("oor_a_hsync", 32'(hsync), 32'd1);
    check("oor_a_vsync", 32'(vsync), 32'd1);
    check("oor_a_rgb", 32'(rgb), 32'h000);
    cyc(10'd1000, 10'd491);
    check("oor_b_vsync", 32'(vsync), 32'd1);
    check("oor_b_rgb", 32'(rgb), 32'h000);

    // mid-frame reset while drawing a visible cell
    cyc(10'd300, 10'd200);
    cyc(10'd300, 10'd200);
    cyc(10'd300, 10'd200);
    check("pre_rst_blue", 32'(rgb), 32'h00F);
    ticks = 0;
    rst = 1'b1;
    cyc(10'd300, 10'd200);
    check("mid_rst_rgb", 32'(rgb), 32'h000);
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_vsync", 32'(vsync), 32'd1);
    check("mid_rst_addr", 32'(rd_addr), 32'h000);
    if (frame_tick) ticks++;
    rst = 1'b0;
    cyc(10'd301, 10'd200);
    check("flush_e1_rgb", 32'(rgb), 32'h000);
    if (frame_tick) ticks++;
    cyc(10'd302, 10'd200);
    check("flush_e2_rgb", 32'(rgb), 32'h000);
    if (frame_tick) ticks++;
    cyc(10'd303, 10'd200);
    check("post_rst_blue", 32'(rgb), 32'h00F);
    if (frame_tick) ticks++;
    check("no_stale_tick", 32'(ticks), 32'd0);
    cyc(10'd0, 10'd480);
    cyc(10'd0, 10'd480);
    check("tick_not_early", 32'(frame_tick), 32'd0);
    cyc(10'd0, 10'd480);
    check("tick_after_rst", 32'(frame_tick), 32'd1);
    cyc(10'd1, 10'd480);
    check("tick_width", 32'(frame_tick), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
